// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory access path: access-size
// encodings, the access-unit state enum and the bus-watchdog default.
package mips_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HW   = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    localparam int TIMEOUT_DEF = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus: one req/ack transaction with word address, byte
// enables and lane-positioned write data. master = access unit side,
// slave = memory side.
interface mem_access_unit_if;

    logic        mem_req_out;
    logic        mem_we_out;
    logic [29:0] mem_addr_out;
    logic [3:0]  mem_be_out;
    logic [31:0] mem_wdata_out;
    logic [31:0] mem_rdata_in;
    logic        mem_ack_in;

    modport master (
        output mem_req_out, mem_we_out, mem_addr_out, mem_be_out, mem_wdata_out,
        input  mem_rdata_in, mem_ack_in
    );

    modport slave (
        input  mem_req_out, mem_we_out, mem_addr_out, mem_be_out, mem_wdata_out,
        output mem_rdata_in, mem_ack_in
    );

endinterface

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/halfword lane out of the
// bus word and sign- or zero-extends it to 32 bits.
module load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        zext,
    output logic [31:0] out
);
    import mips_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension according to the access size
    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: out = {{24{~zext & byte_sel[7]}}, byte_sel};
            SIZE_HW:   out = {{16{~zext & half_sel[15]}}, half_sel};
            default:   out = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle data-memory access unit: accepts a decoded load/store,
// runs one req/ack bus transaction and returns aligned load data, holding
// stall_out while the access is in flight.
// Optional feature: define MEM_TIMEOUT_EN to add a bus watchdog that
// abandons a request after TIMEOUT cycles without acknowledge.
module mem_access_unit #(
    parameter int TIMEOUT = mips_pkg::TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  re_in,
    input  logic                  we_in,
    input  logic [1:0]            size_in,
    input  logic                  zext_in,
    input  logic [31:0]           addr_in,
    input  logic [31:0]           wdata_in,
    mem_access_unit_if.master     bus,
    output logic [31:0]           rdata_out,
    output logic                  stall_out,
    output logic                  wb_kill_out,
    output logic                  err_align_out,
    output logic                  err_bus_out
);
    import mips_pkg::*;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [29:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        zext_q, zext_d;
    logic        ld_q, ld_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;

    logic        access;
    logic        legal;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] aligned;
    logic        timeout_hit;
    logic        to_kill;

    // Legality check and store lane generation for the presented access
    always_comb begin
        access    = re_in | we_in;
        legal     = 1'b0;
        be_new    = 4'b0000;
        wdata_new = wdata_in;
        case (size_in)
            SIZE_BYTE: begin
                legal     = 1'b1;
                be_new    = 4'b0001 << addr_in[1:0];
                wdata_new = {4{wdata_in[7:0]}};
            end
            SIZE_HW: begin
                legal     = ~addr_in[0];
                be_new    = addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{wdata_in[15:0]}};
            end
            SIZE_WORD: begin
                legal     = (addr_in[1:0] == 2'b00);
                be_new    = 4'b1111;
                wdata_new = wdata_in;
            end
            default: legal = 1'b0;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;

    // Watchdog: counts ack-less REQ cycles, zero whenever not in REQ
    always_comb begin
        cnt_d       = cnt_q;
        to_d        = to_q;
        timeout_hit = (state_q == ST_REQ) && !bus.mem_ack_in &&
                      (cnt_q == CNT_W'(TIMEOUT - 1));
        if (state_q != ST_REQ)
            cnt_d = '0;
        else if (!bus.mem_ack_in)
            cnt_d = cnt_q + 1'b1;
        if (state_q == ST_IDLE)
            to_d = 1'b0;
        else if (timeout_hit)
            to_d = 1'b1;
    end

    // Watchdog registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign err_bus_out = timeout_hit;
    assign to_kill     = to_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign err_bus_out    = 1'b0;
    assign to_kill        = 1'b0;
`endif

    load_align u_load_align (
        .rdata (rbuf_q),
        .off   (off_q),
        .size  (size_q),
        .zext  (zext_q),
        .out   (aligned)
    );

    // FSM next state, captured transaction fields and pipeline control
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        off_d         = off_q;
        size_d        = size_q;
        zext_d        = zext_q;
        ld_d          = ld_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        rbuf_d        = rbuf_q;
        stall_out     = 1'b0;
        wb_kill_out   = 1'b0;
        err_align_out = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access && legal) begin
                    // we_in takes priority: a store with re_in also set is a store
                    stall_out = 1'b1;
                    state_d   = ST_REQ;
                    req_d     = 1'b1;
                    we_d      = we_in;
                    ld_d      = ~we_in;
                    addr_d    = addr_in[31:2];
                    off_d     = addr_in[1:0];
                    size_d    = size_in;
                    zext_d    = zext_in;
                    be_d      = be_new;
                    wdata_d   = wdata_new;
                end else if (access) begin
                    err_align_out = 1'b1;
                    wb_kill_out   = 1'b1;
                end
            end
            ST_REQ: begin
                stall_out   = 1'b1;
                wb_kill_out = 1'b1;
                if (bus.mem_ack_in) begin
                    req_d   = 1'b0;
                    rbuf_d  = bus.mem_rdata_in;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    ld_d    = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                wb_kill_out = to_kill;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        rdata_out = ((state_q == ST_DONE) && ld_q) ? aligned : 32'h0;
    end

    // State and bus-output registers; reset aborts any transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            zext_q  <= 1'b0;
            ld_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            size_q  <= size_d;
            zext_q  <= zext_d;
            ld_q    <= ld_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
        end
    end

    assign bus.mem_req_out   = req_q;
    assign bus.mem_we_out    = we_q;
    assign bus.mem_addr_out  = addr_q;
    assign bus.mem_be_out    = be_q;
    assign bus.mem_wdata_out = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases with literal expectations plus
// a randomized phase, all checked every cycle against a transaction-level
// model of the access unit.
module tb_mem_access_unit;

    localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        re_in = 1'b0, we_in = 1'b0, zext_in = 1'b0;
    logic [1:0]  size_in = 2'b00;
    logic [31:0] addr_in = '0, wdata_in = '0;
    logic [31:0] rdata_out;
    logic        stall_out, wb_kill_out, err_align_out, err_bus_out;

    mem_access_unit_if bus();

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .re_in         (re_in),
        .we_in         (we_in),
        .size_in       (size_in),
        .zext_in       (zext_in),
        .addr_in       (addr_in),
        .wdata_in      (wdata_in),
        .bus           (bus),
        .rdata_out     (rdata_out),
        .stall_out     (stall_out),
        .wb_kill_out   (wb_kill_out),
        .err_align_out (err_align_out),
        .err_bus_out   (err_bus_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk1(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference helpers ----------------
    function automatic int nbytes(input logic [1:0] s);
        case (s)
            2'b00: return 1;
            2'b01: return 2;
            2'b11: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [1:0] s, input logic [31:0] a);
        int n = nbytes(s);
        return (n != 0) && ((int'(a[1:0]) % n) == 0);
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] s, input logic [1:0] off);
        int n = nbytes(s);
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] s, input logic [31:0] w);
        int n = nbytes(s);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [31:0] rd, input logic [1:0] off,
                                           input logic [1:0] s, input logic z);
        int n = nbytes(s);
        logic [31:0] v, mask;
        v    = rd >> (8 * off);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v    = v & mask;
        if (!z && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- transaction-level model ----------------
    bit          m_busy, m_done, m_to;
    int          m_wait;
    logic        e_we, e_zext;
    logic [1:0]  e_off, e_size;
    logic [29:0] e_wa;
    logic [3:0]  e_be;
    logic [31:0] e_wd, m_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_to = 0; m_wait = 0;
            e_we = 0; e_zext = 0; e_off = 0; e_size = 0;
            e_wa = '0; e_be = '0; e_wd = '0; m_rdata = '0;
        end else if (m_done) begin
            m_done = 0;
            m_to   = 0;
        end else if (m_busy) begin
            if (bus.mem_ack_in) begin
                m_rdata = bus.mem_rdata_in;
                m_busy  = 0;
                m_done  = 1;
            end else if (TO_EN && m_wait == TO - 1) begin
                m_busy = 0;
                m_done = 1;
                m_to   = 1;
            end else begin
                m_wait++;
            end
        end else if ((re_in || we_in) && is_legal(size_in, addr_in)) begin
            m_busy = 1;
            m_wait = 0;
            e_we   = we_in;
            e_zext = zext_in;
            e_off  = addr_in[1:0];
            e_size = size_in;
            e_wa   = addr_in[31:2];
            e_be   = exp_be(size_in, addr_in[1:0]);
            e_wd   = exp_wd(size_in, wdata_in);
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (rst_n) begin
            bit acc, leg, idle;
            acc  = re_in || we_in;
            leg  = is_legal(size_in, addr_in);
            idle = !m_busy && !m_done;
            chk1 ("req",       bus.mem_req_out, m_busy);
            chk1 ("we",        bus.mem_we_out, e_we);
            chk32("addr",      32'(bus.mem_addr_out), 32'(e_wa));
            chk32("be",        32'(bus.mem_be_out), 32'(e_be));
            chk32("wdata",     bus.mem_wdata_out, e_wd);
            chk1 ("stall",     stall_out, m_busy || (idle && acc && leg));
            chk1 ("wb_kill",   wb_kill_out, m_busy || (idle && acc && !leg) || (m_done && m_to));
            chk1 ("err_align", err_align_out, idle && acc && !leg);
            chk1 ("err_bus",   err_bus_out, TO_EN && m_busy && !bus.mem_ack_in && (m_wait == TO - 1));
            chk32("rdata",     rdata_out,
                  (m_done && !e_we && !m_to) ? exp_ld(m_rdata, e_off, e_size, e_zext) : 32'h0);
        end
    end

    // ---------------- memory responder ----------------
    int          resp_delay = 0;
    bit          resp_rand  = 0;
    bit          spur_en    = 0;
    logic [31:0] resp_data  = '0;
    int          req_cnt    = 0;
    int          cur_delay  = 0;

    always @(posedge clk) begin
        #1;
        if (bus.mem_req_out) begin
            if (req_cnt == 0) cur_delay = resp_rand ? int'($urandom_range(0, 5)) : resp_delay;
            bus.mem_ack_in   = (req_cnt == cur_delay);
            bus.mem_rdata_in = (req_cnt == cur_delay && !resp_rand) ? resp_data : $urandom;
            req_cnt++;
        end else begin
            req_cnt          = 0;
            bus.mem_ack_in   = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_rdata_in = $urandom;
        end
    end

    // ---------------- directed access helper ----------------
    task automatic run_access(
        input  logic re, input logic we, input logic [1:0] sz, input logic z,
        input  logic [31:0] a, input logic [31:0] wd, input int dly, input logic [31:0] rd,
        output int stall_n, output bit saw_req, output logic r_we, output logic [3:0] r_be,
        output logic [29:0] r_addr, output logic [31:0] r_wd, output logic [31:0] r_rdata,
        output logic acc_err, output logic acc_kill, output int bus_err_at);
        bit done = 0;
        resp_rand = 0; resp_delay = dly; resp_data = rd;
        saw_req = 0; r_we = 0; r_be = '0; r_addr = '0; r_wd = '0; r_rdata = '0;
        bus_err_at = -1;
        @(posedge clk); #1;
        re_in = re; we_in = we; size_in = sz; zext_in = z; addr_in = a; wdata_in = wd;
        @(negedge clk);
        stall_n  = int'(stall_out);
        acc_err  = err_align_out;
        acc_kill = wb_kill_out;
        @(posedge clk); #1;
        re_in = 0; we_in = 0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            if (bus.mem_req_out && !saw_req) begin
                saw_req = 1; r_we = bus.mem_we_out; r_be = bus.mem_be_out;
                r_addr = bus.mem_addr_out; r_wd = bus.mem_wdata_out;
            end
            if (err_bus_out) bus_err_at = c;
            if (!stall_out) begin
                r_rdata = rdata_out;
                done = 1;
            end else begin
                stall_n++;
            end
        end
        chk1("txn_completes", done, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    int          st_n, berr;
    bit          sreq;
    logic        rwe, aerr, akill;
    logic [3:0]  rbe;
    logic [29:0] raddr;
    logic [31:0] rwd, rrd;

    initial begin
        bus.mem_ack_in = 1'b0;
        bus.mem_rdata_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1 ("reset_req",   bus.mem_req_out, 1'b0);
        chk1 ("reset_we",    bus.mem_we_out, 1'b0);
        chk32("reset_addr",  32'(bus.mem_addr_out), 32'h0);
        chk32("reset_be",    32'(bus.mem_be_out), 32'h0);
        chk32("reset_wdata", bus.mem_wdata_out, 32'h0);
        chk32("reset_rdata", rdata_out, 32'h0);
        chk1 ("reset_stall", stall_out, 1'b0);
        chk1 ("reset_kill",  wb_kill_out, 1'b0);
        chk1 ("reset_ealign", err_align_out, 1'b0);
        chk1 ("reset_ebus",  err_bus_out, 1'b0);
        @(posedge clk); #3; rst_n = 1'b1;

        // lb at 0x1003, ack in the second REQ cycle
        run_access(1, 0, 2'b00, 0, 32'h1003, 32'h0, 1, 32'h80AA55CC,
                   st_n, sreq, rwe, rbe, raddr, rwd, rrd, aerr, akill, berr);
        chk32("lb_be", 32'(rbe), 32'h8);
        chk32("lb_addr", 32'(raddr), 32'h400);
        chk32("lb_rdata", rrd, 32'hFFFFFF80);
        chk32("lb_stall_cycles", st_n, 3);

        // lbu, same address and data
        run_access(1, 0, 2'b00, 1, 32'h1003, 32'h0, 1, 32'h80AA55CC,
                   st_n, sreq, rwe, rbe, raddr, rwd, rrd, aerr, akill, berr);
        chk32("lbu_rdata", rrd, 32'h00000080);

        // sh at 0x2002
        run_access(0, 1, 2'b01, 0, 32'h2002, 32'h0000BEEF, 0, 32'h0,
                   st_n, sreq, rwe, rbe, raddr, rwd, rrd, aerr, akill, berr);
        chk1 ("sh_we", rwe, 1'b1);
        chk32("sh_be", 32'(rbe), 32'hC);
        chk32("sh_wdata", rwd, 32'hBEEFBEEF);
        chk32("sh_addr", 32'(raddr), 32'h800);
        chk32("sh_rdata", rrd, 32'h0);

        // misaligned lw at 0x0006
        run_access(1, 0, 2'b11, 0, 32'h0006, 32'h0, 0, 32'h0,
                   st_n, sreq, rwe, rbe, raddr, rwd, rrd, aerr, akill, berr);
        chk1 ("lw_mis_err", aerr, 1'b1);
        chk1 ("lw_mis_kill", akill, 1'b1);
        chk1 ("lw_mis_req", sreq, 1'b0);
        chk32("lw_mis_stall", st_n, 0);

        // illegal size 10
        run_access(1, 0, 2'b10, 0, 32'h0000, 32'h0, 0, 32'h0,
                   st_n, sreq, rwe, rbe, raddr, rwd, rrd, aerr, akill, berr);
        chk1 ("size10_err", aerr, 1'b1);
        chk1 ("size10_req", sreq, 1'b0);

        // re and we together: store wins
        run_access(1, 1, 2'b11, 0, 32'h0010, 32'h12345678, 0, 32'hCAFEF00D,
                   st_n, sreq, rwe, rbe, raddr, rwd, rrd, aerr, akill, berr);
        chk1 ("both_we", rwe, 1'b1);
        chk32("both_wdata", rwd, 32'h12345678);
        chk32("both_rdata", rrd, 32'h0);

        // minimum latency lw, ack in first REQ cycle
        run_access(1, 0, 2'b11, 0, 32'h0020, 32'h0, 0, 32'hDEADBEEF,
                   st_n, sreq, rwe, rbe, raddr, rwd, rrd, aerr, akill, berr);
        chk32("lw_rdata", rrd, 32'hDEADBEEF);
        chk32("lw_stall_cycles", st_n, 2);
        chk32("lw_be", 32'(rbe), 32'hF);

        // lh upper half, sign extended
        run_access(1, 0, 2'b01, 0, 32'h0022, 32'h0, 2, 32'h80017F00,
                   st_n, sreq, rwe, rbe, raddr, rwd, rrd, aerr, akill, berr);
        chk32("lh_rdata", rrd, 32'hFFFF8001);
        chk32("lh_be", 32'(rbe), 32'hC);

        // slow bus: watchdog fires after TO REQ cycles, otherwise REQ waits
`ifdef MEM_TIMEOUT_EN
        run_access(1, 0, 2'b11, 0, 32'h0040, 32'h0, 100, 32'h11111111,
                   st_n, sreq, rwe, rbe, raddr, rwd, rrd, aerr, akill, berr);
        chk32("to_err_cycle", berr, 4);
        chk32("to_rdata", rrd, 32'h0);
        chk32("to_stall_cycles", st_n, 5);
`else
        run_access(1, 0, 2'b11, 0, 32'h0040, 32'h0, 20, 32'h11111111,
                   st_n, sreq, rwe, rbe, raddr, rwd, rrd, aerr, akill, berr);
        chk32("wait_no_err", berr, -1);
        chk32("wait_rdata", rrd, 32'h11111111);
        chk32("wait_stall_cycles", st_n, 22);
`endif

        // reset in the second REQ cycle
        resp_rand = 0; resp_delay = 50; spur_en = 0;
        @(posedge clk); #1;
        re_in = 1; size_in = 2'b11; addr_in = 32'h0080; zext_in = 0;
        @(posedge clk); #1;
        re_in = 0;
        @(posedge clk); #3;
        chk1("rst_mid_req_before", bus.mem_req_out, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1 ("rst_mid_req_async", bus.mem_req_out, 1'b0);
        chk1 ("rst_mid_stall", stall_out, 1'b0);
        chk32("rst_mid_be", 32'(bus.mem_be_out), 32'h0);
        spur_en = 1;
        @(posedge clk); #3; rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1 ("rst_after_req", bus.mem_req_out, 1'b0);
            chk1 ("rst_after_stall", stall_out, 1'b0);
            chk32("rst_after_rdata", rdata_out, 32'h0);
        end

        // randomized traffic, random ack delays and stray acks
        resp_rand = 1; spur_en = 1;
        for (int i = 0; i < 800; i++) begin
            logic [31:0] a;
            @(posedge clk); #1;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            re_in    = 1'($urandom_range(0, 1));
            we_in    = ($urandom_range(0, 3) == 0);
            size_in  = 2'($urandom_range(0, 3));
            zext_in  = 1'($urandom_range(0, 1));
            addr_in  = a;
            wdata_in = $urandom;
        end
        @(posedge clk); #1;
        re_in = 0; we_in = 0;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
